systolic_feeder: RTL



---
 rtl/systolic_feeder_pkg.sv | 24 ++
 rtl/feeder_operand_buf.sv | 53 +++++
 rtl/systolic_feeder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/systolic_feeder_pkg.sv
// systolic_feeder_pkg: shared array sizing, feeder FSM states and lane helper.
// No ports; imported by systolic_feeder and feeder_operand_buf.
package systolic_feeder_pkg;

  localparam int ARR_SIZE_DEF = 4;
  localparam int HBW_DEF      = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FEED,
    DRAIN,
    DONE
  } state_e;

  // Low bit of lane `lane` in a packed bus of `bw`-bit lanes.
  function automatic int unsigned lane_lsb(
    input int unsigned lane,
    input int unsigned bw
  );
    return lane * bw;
  endfunction

endpackage

// File: rtl/feeder_operand_buf.sv
// feeder_operand_buf: K_MAX-deep operand store, one write port, ARR_SIZE read ports.
// Ports: clk, we/wr_addr/wr_a/wr_b write side; rd_idx per lane -> rd_a/rd_b (comb).
module feeder_operand_buf
  import systolic_feeder_pkg::*;
#(
  parameter int ARR_SIZE = ARR_SIZE_DEF,
  parameter int HBW      = HBW_DEF,
  parameter int K_MAX    = 16,
  localparam int AW      = $clog2(K_MAX),
  localparam int VW      = ARR_SIZE * HBW
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [AW-1:0]                wr_addr,
  input  logic [VW-1:0]                wr_a,
  input  logic [VW-1:0]                wr_b,
  input  logic [ARR_SIZE-1:0][AW-1:0]  rd_idx,
  output logic [VW-1:0]                rd_a,
  output logic [VW-1:0]                rd_b
);

  logic [VW-1:0] a_q [K_MAX];
  logic [VW-1:0] a_d [K_MAX];
  logic [VW-1:0] b_q [K_MAX];
  logic [VW-1:0] b_d [K_MAX];

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (we) begin
      a_d[wr_addr] = wr_a;
      b_d[wr_addr] = wr_b;
    end
  end

  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  // Each read port returns only its own lane of the addressed beat.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < ARR_SIZE; i++) begin
      rd_a[lane_lsb(i, HBW) +: HBW] =
        a_q[rd_idx[i]][lane_lsb(i, HBW) +: HBW];
      rd_b[lane_lsb(i, HBW) +: HBW] =
        b_q[rd_idx[i]][lane_lsb(i, HBW) +: HBW];
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: loads a tile of A/B beats, replays them skewed (lane i late by i).
// Ports: s_* load handshake; o_horizontal/o_vertical/o_mode/o_feed_valid to array; busy, done.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int ARR_SIZE      = ARR_SIZE_DEF,
  parameter int HORIZONTAL_BW = HBW_DEF,
  parameter int K_MAX         = 16,
  parameter int DRAIN_CYCLES  = 8,
  localparam int VW           = ARR_SIZE * HORIZONTAL_BW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_mode,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [VW-1:0] s_a_vec,
  input  logic [VW-1:0] s_b_vec,
  input  logic          s_last,
  output logic [VW-1:0] o_horizontal,
  output logic [VW-1:0] o_vertical,
  output logic          o_mode,
  output logic          o_feed_valid,
  output logic          busy,
  output logic          done
);

  localparam int AW = $clog2(K_MAX);
  localparam int KW = $clog2(K_MAX + 1);
  localparam int CW = $clog2(K_MAX + ARR_SIZE + DRAIN_CYCLES + 1);
  localparam int HB = HORIZONTAL_BW;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [KW-1:0] k_q, k_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic [VW-1:0] hor_q, hor_d;
  logic [VW-1:0] ver_q, ver_d;
  logic          fv_q, fv_d;

  logic                        accept;
  logic                        last_beat;
  logic [ARR_SIZE-1:0][AW-1:0] rd_idx;
  logic [ARR_SIZE-1:0]         lane_on;
  logic [VW-1:0]               rd_a, rd_b;

  assign s_ready      = (state_q == IDLE || state_q == LOAD) && !rst;
  assign accept       = s_valid && s_ready;
  assign last_beat    = s_last || (wr_ptr_q == AW'(K_MAX - 1));
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign o_horizontal = hor_q;
  assign o_vertical   = ver_q;
  assign o_mode       = mode_q;
  assign o_feed_valid = fv_q;

  feeder_operand_buf #(
    .ARR_SIZE (ARR_SIZE),
    .HBW      (HORIZONTAL_BW),
    .K_MAX    (K_MAX)
  ) u_buf (
    .clk     (clk),
    .we      (accept),
    .wr_addr (wr_ptr_q),
    .wr_a    (s_a_vec),
    .wr_b    (s_b_vec),
    .rd_idx  (rd_idx),
    .rd_a    (rd_a),
    .rd_b    (rd_b)
  );

  // During FEED cnt_q is the step t; lane i shows beat t-i when in range.
  always_comb begin
    rd_idx  = '0;
    lane_on = '0;
    for (int i = 0; i < ARR_SIZE; i++) begin
      lane_on[i] = (cnt_q >= CW'(i)) &&
                   ((cnt_q - CW'(i)) < CW'(k_q));
      rd_idx[i]  = AW'(cnt_q - CW'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    hor_d    = '0;
    ver_d    = '0;
    fv_d     = 1'b0;
    unique case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          wr_ptr_d = wr_ptr_q + AW'(1);
          state_d  = LOAD;
          if (state_q == IDLE) mode_d = cfg_mode;
          if (last_beat) begin
            k_d      = KW'(wr_ptr_q) + KW'(1);
            wr_ptr_d = '0;
            cnt_d    = '0;
            state_d  = FEED;
          end
        end
      end
      FEED: begin
        fv_d  = 1'b1;
        cnt_d = cnt_q + CW'(1);
        for (int i = 0; i < ARR_SIZE; i++) begin
          if (lane_on[i]) begin
            hor_d[lane_lsb(i, HB) +: HB] = rd_a[lane_lsb(i, HB) +: HB];
            ver_d[lane_lsb(i, HB) +: HB] = rd_b[lane_lsb(i, HB) +: HB];
          end
        end
        if (cnt_q == CW'(k_q) + CW'(ARR_SIZE - 2)) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The last feed step is still on the bus during cnt_q==0,
        // so zeros are shown for cnt_q 1..DRAIN_CYCLES.
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DRAIN_CYCLES)) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        cnt_d    = '0;
        wr_ptr_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      hor_q    <= '0;
      ver_q    <= '0;
      fv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      hor_q    <= hor_d;
      ver_q    <= ver_d;
      fv_q     <= fv_d;
    end
  end

endmodule
